// File: rtl/cv32e40x_pkg.sv
// Shared types for the register-file write scoreboard.
// Purely declarative: no logic, no latency, no flow control.
package cv32e40x_pkg;

   typedef logic [4:0] rf_addr_t;

   typedef struct packed {
      rf_addr_t waddr;
      logic     is_load;
   } sb_entry_t;

endpackage

// File: rtl/cv32e40x_sb_fifo.sv
// In-order queue of tracked register writes with count-based full/empty and flush.
// Push/pop visible next cycle; push ignored when full, pop ignored when empty.
module cv32e40x_sb_fifo
   import cv32e40x_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  sb_entry_t     push_dat_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic          full_o,
   output logic          empty_o,
   output sb_entry_t     head_o,
   output logic [CW-1:0] count_o
);

   sb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_wptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push = push_i & ~full_o;
   assign w_pop  = pop_i & ~empty_o;

   // Pointers wrap naturally at DEPTH (power of two); occupancy comes from r_count only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush_i) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= push_dat_i;
            r_wptr        <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign empty_o = (r_count == '0);
   assign full_o  = (r_count == CW'(DEPTH));
   assign head_o  = empty_o ? '0 : r_mem[r_rptr];
   assign count_o = r_count;

endmodule

// File: rtl/cv32e40x_rf_scoreboard.sv
// Tracks in-flight RF writes from ID and retires them in order from WB; answers ID read hazards.
// Queries are zero-latency on registered state; issue_ready_o drops when DEPTH writes are pending.
module cv32e40x_rf_scoreboard
   import cv32e40x_pkg::*;
#(
   parameter  int DEPTH    = 4,
   parameter  int NUM_REGS = 32,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid_i,
   input  logic            issue_we_i,
   input  logic [4:0]      issue_waddr_i,
   input  logic            issue_is_load_i,
   output logic            issue_ready_o,
   input  logic            wb_valid_i,
   input  logic            flush_i,
   input  logic [1:0]      rf_re_i,
   input  logic [1:0][4:0] rf_raddr_i,
   output logic [1:0]      rd_pending_o,
   output logic [1:0]      rd_load_pending_o,
   output logic            load_stall_o,
   output logic            head_valid_o,
   output logic [4:0]      head_waddr_o,
   output logic            head_is_load_o,
   output logic [CW-1:0]   count_o,
   output logic            underflow_o
);

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   sb_entry_t     w_push_dat;
   sb_entry_t     w_head;
   logic          w_inc    [NUM_REGS];
   logic          w_dec    [NUM_REGS];
   logic          w_ld_inc [NUM_REGS];
   logic          w_ld_dec [NUM_REGS];
   logic [CW-1:0] r_pend_cnt [NUM_REGS];
   logic [CW-1:0] r_ld_cnt   [NUM_REGS];
   logic          r_underflow;

   assign w_push = issue_valid_i & issue_we_i & (issue_waddr_i != '0) & ~w_full & ~flush_i;
   assign w_pop  = wb_valid_i & ~w_empty & ~flush_i;

   assign w_push_dat.waddr   = issue_waddr_i;
   assign w_push_dat.is_load = issue_is_load_i;

   cv32e40x_sb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (w_push),
      .push_dat_i (w_push_dat),
      .pop_i      (w_pop),
      .flush_i    (flush_i),
      .full_o     (w_full),
      .empty_o    (w_empty),
      .head_o     (w_head),
      .count_o    (count_o)
   );

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         w_inc[r]    = w_push && (w_push_dat.waddr == rf_addr_t'(r));
         w_dec[r]    = w_pop && (w_head.waddr == rf_addr_t'(r));
         w_ld_inc[r] = w_inc[r] && w_push_dat.is_load;
         w_ld_dec[r] = w_dec[r] && w_head.is_load;
      end
   end

   // A same-register push and pop in one cycle cancel, leaving the counter untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_pend_cnt[r] <= '0;
            r_ld_cnt[r]   <= '0;
         end
      end else if (flush_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_pend_cnt[r] <= '0;
            r_ld_cnt[r]   <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            case ({w_inc[r], w_dec[r]})
               2'b10:   r_pend_cnt[r] <= r_pend_cnt[r] + CW'(1);
               2'b01:   r_pend_cnt[r] <= r_pend_cnt[r] - CW'(1);
               default: ;
            endcase
            case ({w_ld_inc[r], w_ld_dec[r]})
               2'b10:   r_ld_cnt[r] <= r_ld_cnt[r] + CW'(1);
               2'b01:   r_ld_cnt[r] <= r_ld_cnt[r] - CW'(1);
               default: ;
            endcase
         end
      end
   end

   // Sticky until reset; flush deliberately leaves it alone so the error is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underflow <= 1'b0;
      end else if (wb_valid_i && w_empty) begin
         r_underflow <= 1'b1;
      end
   end

   always_comb begin
      rd_pending_o      = '0;
      rd_load_pending_o = '0;
      for (int i = 0; i < 2; i++) begin
         rd_pending_o[i]      = rf_re_i[i] && (rf_raddr_i[i] != '0) &&
                                (r_pend_cnt[rf_raddr_i[i]] != '0);
         rd_load_pending_o[i] = rf_re_i[i] && (rf_raddr_i[i] != '0) &&
                                (r_ld_cnt[rf_raddr_i[i]] != '0);
      end
   end

   assign load_stall_o   = |rd_load_pending_o;
   assign issue_ready_o  = ~w_full;
   assign head_valid_o   = ~w_empty;
   assign head_waddr_o   = w_head.waddr;
   assign head_is_load_o = w_head.is_load;
   assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_cv32e40x_rf_scoreboard.sv
// Directed vector bench for the RF write scoreboard (DEPTH=4).
// Each vector is held for one clock; outputs are compared 1ns after the rising edge.
module tb_cv32e40x_rf_scoreboard;

   typedef struct {
      logic       iv, we;
      logic [4:0] wa;
      logic       ld, wb, fl;
      logic [1:0] re;
      logic [4:0] ra0, ra1;
      int         cnt;
      logic       rdy, hv;
      logic [4:0] hwa;
      logic       hld;
      logic [1:0] pd, lp;
      logic       uf;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            issue_valid_i, issue_we_i, issue_is_load_i;
   logic [4:0]      issue_waddr_i;
   logic            issue_ready_o;
   logic            wb_valid_i, flush_i;
   logic [1:0]      rf_re_i;
   logic [1:0][4:0] rf_raddr_i;
   logic [1:0]      rd_pending_o, rd_load_pending_o;
   logic            load_stall_o, head_valid_o, head_is_load_o, underflow_o;
   logic [4:0]      head_waddr_o;
   logic [2:0]      count_o;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs [$];

   always #5 clk = ~clk;

   cv32e40x_rf_scoreboard #(.DEPTH(4), .NUM_REGS(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .issue_valid_i     (issue_valid_i),
      .issue_we_i        (issue_we_i),
      .issue_waddr_i     (issue_waddr_i),
      .issue_is_load_i   (issue_is_load_i),
      .issue_ready_o     (issue_ready_o),
      .wb_valid_i        (wb_valid_i),
      .flush_i           (flush_i),
      .rf_re_i           (rf_re_i),
      .rf_raddr_i        (rf_raddr_i),
      .rd_pending_o      (rd_pending_o),
      .rd_load_pending_o (rd_load_pending_o),
      .load_stall_o      (load_stall_o),
      .head_valid_o      (head_valid_o),
      .head_waddr_o      (head_waddr_o),
      .head_is_load_o    (head_is_load_o),
      .count_o           (count_o),
      .underflow_o       (underflow_o)
   );

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic iv, we, input logic [4:0] wa, input logic ld, wb, fl,
                      input logic [1:0] re, input logic [4:0] ra0, ra1,
                      input int cnt, input logic rdy, hv, input logic [4:0] hwa,
                      input logic hld, input logic [1:0] pd, lp, input logic uf);
      vec_t v;
      v = '{iv, we, wa, ld, wb, fl, re, ra0, ra1, cnt, rdy, hv, hwa, hld, pd, lp, uf};
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      issue_valid_i   = v.iv;
      issue_we_i      = v.we;
      issue_waddr_i   = v.wa;
      issue_is_load_i = v.ld;
      wb_valid_i      = v.wb;
      flush_i         = v.fl;
      rf_re_i         = v.re;
      rf_raddr_i[0]   = v.ra0;
      rf_raddr_i[1]   = v.ra1;
   endtask

   task automatic check_vec(input vec_t v, input int idx);
      chk("count", idx, 32'(count_o), 32'(v.cnt));
      chk("ready", idx, 32'(issue_ready_o), 32'(v.rdy));
      chk("head_valid", idx, 32'(head_valid_o), 32'(v.hv));
      chk("head_waddr", idx, 32'(head_waddr_o), 32'(v.hwa));
      chk("head_is_load", idx, 32'(head_is_load_o), 32'(v.hld));
      chk("rd_pending", idx, 32'(rd_pending_o), 32'(v.pd));
      chk("rd_load_pending", idx, 32'(rd_load_pending_o), 32'(v.lp));
      chk("load_stall", idx, 32'(load_stall_o), 32'(|v.lp));
      chk("underflow", idx, 32'(underflow_o), 32'(v.uf));
   endtask

   initial begin
      vec_t idle;
      idle = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0,
               0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0};

      // Load-use on x5, ALU write to x7, non-writes and x0 writes
      add(1,1,5,1,0,0,2'b11,5,0,  1,1,1,5,1,2'b01,2'b01,0);
      add(0,0,0,0,1,0,2'b11,5,0,  0,1,0,0,0,2'b00,2'b00,0);
      add(1,1,7,0,0,0,2'b11,7,7,  1,1,1,7,0,2'b11,2'b00,0);
      add(0,0,0,0,1,0,2'b11,7,7,  0,1,0,0,0,2'b00,2'b00,0);
      add(1,0,8,0,0,0,2'b11,8,0,  0,1,0,0,0,2'b00,2'b00,0);
      add(1,1,0,1,0,0,2'b11,0,0,  0,1,0,0,0,2'b00,2'b00,0);
      // Fill to DEPTH, refused issue while full, no pop-to-push bypass, drain in order
      add(1,1,1,0,0,0,2'b11,2,9,  1,1,1,1,0,2'b00,2'b00,0);
      add(1,1,2,1,0,0,2'b11,2,9,  2,1,1,1,0,2'b01,2'b01,0);
      add(1,1,3,0,0,0,2'b11,2,9,  3,1,1,1,0,2'b01,2'b01,0);
      add(1,1,4,1,0,0,2'b11,2,9,  4,0,1,1,0,2'b01,2'b01,0);
      add(1,1,9,0,0,0,2'b11,2,9,  4,0,1,1,0,2'b01,2'b01,0);
      add(1,1,9,0,1,0,2'b11,2,9,  3,1,1,2,1,2'b01,2'b01,0);
      add(0,0,0,0,1,0,2'b11,2,9,  2,1,1,3,0,2'b00,2'b00,0);
      add(0,0,0,0,1,0,2'b11,2,9,  1,1,1,4,1,2'b00,2'b00,0);
      add(0,0,0,0,1,0,2'b11,2,9,  0,1,0,0,0,2'b00,2'b00,0);
      // Two loads to x3 (port 1 disabled), retired one at a time
      add(1,1,3,1,0,0,2'b01,3,3,  1,1,1,3,1,2'b01,2'b01,0);
      add(1,1,3,1,0,0,2'b01,3,3,  2,1,1,3,1,2'b01,2'b01,0);
      add(0,0,0,0,1,0,2'b01,3,3,  1,1,1,3,1,2'b01,2'b01,0);
      add(0,0,0,0,1,0,2'b01,3,3,  0,1,0,0,0,2'b00,2'b00,0);
      // Pointer wrap: occupancy 2, six push/pop pairs, load flag = waddr bit 0
      add(1,1,10,0,0,0,2'b00,0,0, 1,1,1,10,0,2'b00,2'b00,0);
      add(1,1,11,1,0,0,2'b00,0,0, 2,1,1,10,0,2'b00,2'b00,0);
      for (int k = 0; k < 6; k++) begin
         logic [4:0] nw;
         logic [4:0] hw;
         nw = 5'(12 + k);
         hw = 5'(11 + k);
         add(1,1,nw,nw[0],1,0,2'b00,0,0, 2,1,1,hw,hw[0],2'b00,2'b00,0);
      end
      add(0,0,0,0,1,0,2'b00,0,0,  1,1,1,17,1,2'b00,2'b00,0);
      add(0,0,0,0,1,0,2'b00,0,0,  0,1,0,0,0,2'b00,2'b00,0);
      // Same-register push and pop cancel on x6
      add(1,1,6,0,0,0,2'b01,6,0,  1,1,1,6,0,2'b01,2'b00,0);
      add(1,1,6,1,1,0,2'b01,6,0,  1,1,1,6,1,2'b01,2'b01,0);
      add(0,0,0,0,1,0,2'b01,6,0,  0,1,0,0,0,2'b00,2'b00,0);
      // Underflow is sticky; empty+push+wb keeps the push; flush wins but keeps underflow
      add(0,0,0,0,1,0,2'b00,0,0,  0,1,0,0,0,2'b00,2'b00,1);
      add(0,0,0,0,0,0,2'b00,0,0,  0,1,0,0,0,2'b00,2'b00,1);
      add(1,1,12,1,1,0,2'b11,12,13, 1,1,1,12,1,2'b01,2'b01,1);
      add(1,1,13,0,0,0,2'b11,12,13, 2,1,1,12,1,2'b11,2'b01,1);
      add(1,1,14,0,0,0,2'b11,12,13, 3,1,1,12,1,2'b11,2'b01,1);
      add(1,1,15,1,1,1,2'b11,12,13, 0,1,0,0,0,2'b00,2'b00,1);
      add(1,1,13,0,0,0,2'b11,12,13, 1,1,1,13,0,2'b10,2'b00,1);

      drive(idle);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rf_re_i       = 2'b11;
      rf_raddr_i[0] = 5'd5;
      rf_raddr_i[1] = 5'd7;
      #1;
      chk("reset count", -1, 32'(count_o), 32'd0);
      chk("reset ready", -1, 32'(issue_ready_o), 32'd1);
      chk("reset head_valid", -1, 32'(head_valid_o), 32'd0);
      chk("reset rd_pending", -1, 32'(rd_pending_o), 32'd0);
      chk("reset load_stall", -1, 32'(load_stall_o), 32'd0);
      chk("reset underflow", -1, 32'(underflow_o), 32'd0);

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check_vec(vecs[i], i);
      end

      // Asynchronous reset mid-operation: x13 is pending and underflow is set
      drive(idle);
      rf_re_i       = 2'b11;
      rf_raddr_i[1] = 5'd13;
      #2;
      rst = 1'b1;
      #1;
      chk("async rst count", 100, 32'(count_o), 32'd0);
      chk("async rst head_valid", 100, 32'(head_valid_o), 32'd0);
      chk("async rst rd_pending", 100, 32'(rd_pending_o), 32'd0);
      chk("async rst underflow", 100, 32'(underflow_o), 32'd0);
      chk("async rst ready", 100, 32'(issue_ready_o), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
